// File: rtl/fetch_pkg.sv
// Shared widths, the NOP encoding and the fetch-queue entry layout for the fetch stage.
package fetch_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    localparam logic [DEF_DATA_W-1:0] INSTR_NOP = 32'h0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetchEntry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; flush empties it and overrides push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] pushData,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    assign doPush = push && !full && !flush;
    assign doPop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: head is only meaningful while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rdPtr];

endmodule

// File: rtl/fetch_queue_unit.sv
// Decoupled instruction fetch: issues sequential PCs to a latency-tolerant imem and queues
// returned instructions with their PCs; redirects flush the queue and drop in-flight responses.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              Jump,
    input  logic              PCSrcD,
    input  logic [ADDR_W-1:0] PCJumpD,
    input  logic [ADDR_W-1:0] PCBranchD,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              InstrValidF,
    output logic [DATA_W-1:0] InstrF,
    output logic [ADDR_W-1:0] PCF,
    output logic [ADDR_W-1:0] PCPlus4F
);

    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam int                ENT_W   = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(DATA_W / 8);

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] rspPc;
    logic [ADDR_W-1:0] redirTarget;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  outstandingNext;
    logic [CNT_W-1:0]  dropCnt;
    logic [CNT_W-1:0]  qCount;
    logic [CNT_W:0]    credit;
    logic              redir;
    logic              reqFire;
    logic              rspSeen;
    logic              rspDrop;
    logic              qPush;
    logic              qPop;
    logic              qFull;
    logic              qEmpty;
    logic [ENT_W-1:0]  qHead;

    assign redir       = Jump | PCSrcD;
    assign redirTarget = Jump ? PCJumpD : PCBranchD;

    // Stale responses still hold a credit until they return, so they are subtracted out.
    assign credit = {1'b0, qCount} + {1'b0, outstanding} - {1'b0, dropCnt};

    assign imem_req_valid = !rst && !redir && (credit < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetchPc;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign rspSeen = imem_rsp_valid && (outstanding != '0);
    assign rspDrop = rspSeen && (dropCnt != '0);
    assign qPush   = rspSeen && (dropCnt == '0) && !redir;
    assign qPop    = InstrValidF && !StallF && !redir;

    always_comb begin
        outstandingNext = outstanding;
        case ({reqFire, rspSeen})
            2'b10:   outstandingNext = outstanding + 1'b1;
            2'b01:   outstandingNext = outstanding - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            rspPc       <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstandingNext;
            if (redir) begin
                fetchPc <= redirTarget;
                rspPc   <= redirTarget;
                dropCnt <= outstandingNext;
            end else begin
                if (reqFire) fetchPc <= fetchPc + PC_STEP;
                if (qPush)   rspPc   <= rspPc + PC_STEP;
                if (rspDrop) dropCnt <= dropCnt - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (qPush),
        .pop      (qPop),
        .flush    (redir),
        .pushData ({rspPc, imem_rsp_data}),
        .full     (qFull),
        .empty    (qEmpty),
        .count    (qCount),
        .head     (qHead)
    );

    noPushWhenFull : assert property (@(posedge clk) disable iff (rst) !(qPush && qFull));

    assign InstrValidF = !qEmpty;
    assign InstrF      = InstrValidF ? qHead[DATA_W-1:0] : DATA_W'(INSTR_NOP);
    assign PCF         = InstrValidF ? qHead[ENT_W-1:DATA_W] : '0;
    assign PCPlus4F    = PCF + PC_STEP;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        Jump;
    logic        PCSrcD;
    logic [31:0] PCJumpD;
    logic [31:0] PCBranchD;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        InstrValidF;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pq[$];
    int    edgeCnt = 0;
    int    lat     = 1;

    fetch_queue_unit #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .StallF         (StallF),
        .Jump           (Jump),
        .PCSrcD         (PCSrcD),
        .PCJumpD        (PCJumpD),
        .PCBranchD      (PCBranchD),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrValidF    (InstrValidF),
        .InstrF         (InstrF),
        .PCF            (PCF),
        .PCPlus4F       (PCPlus4F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, then advance the memory model.
    task automatic tick();
        logic        fire;
        logic [31:0] a;
        pend_t       p;
        #1;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        @(posedge clk);
        #1;
        edgeCnt++;
        if (rst) begin
            pq.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            if (fire) begin
                p.addr = a;
                p.due  = edgeCnt + lat;
                pq.push_back(p);
            end
            if (pq.size() > 0 && pq[0].due == edgeCnt + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = {16'hC0DE, pq[0].addr[15:0]};
                void'(pq.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        StallF         = 1'b0;
        Jump           = 1'b0;
        PCSrcD         = 1'b0;
        PCJumpD        = '0;
        PCBranchD      = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;

        #2;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_valid", InstrValidF, 0);
        chk("rst_instr", InstrF, 0);
        chk("rst_pcf", PCF, 0);
        chk("rst_pcplus4", PCPlus4F, 32'h4);

        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, 32'h0);
        chk("first_instr_valid", InstrValidF, 0);

        // Zero-latency streaming
        tick();
        chk("stream_lat_empty", InstrValidF, 0);
        tick();
        chk("stream_pc0", PCF, 32'h0);
        chk("stream_instr0", InstrF, 32'hC0DE_0000);
        chk("stream_plus0", PCPlus4F, 32'h4);
        tick();
        chk("stream_pc4", PCF, 32'h4);
        chk("stream_instr4", InstrF, 32'hC0DE_0004);
        chk("stream_plus4", PCPlus4F, 32'h8);
        tick();
        chk("stream_pc8", PCF, 32'h8);
        chk("stream_instr8", InstrF, 32'hC0DE_0008);

        // Stall: queue fills, credits stop further requests
        StallF = 1'b1;
        repeat (10) tick();
        chk("stall_valid", InstrValidF, 1);
        chk("stall_head_pc", PCF, 32'h8);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_req_addr", imem_req_addr, 32'h18);
        StallF = 1'b0;
        tick();
        chk("release_pc12", PCF, 32'hC);
        chk("release_instr12", InstrF, 32'hC0DE_000C);
        tick();
        chk("release_pc16", PCF, 32'h10);
        tick();
        chk("release_pc20", PCF, 32'h14);
        tick();
        chk("release_pc24", PCF, 32'h18);
        chk("release_instr24", InstrF, 32'hC0DE_0018);
        tick();
        chk("release_pc28", PCF, 32'h1C);

        // Mid-stream reset takes effect immediately
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        chk("midrst_req_valid", imem_req_valid, 0);
        chk("midrst_valid", InstrValidF, 0);
        chk("midrst_instr", InstrF, 0);
        chk("midrst_pcf", PCF, 0);
        chk("midrst_pcplus4", PCPlus4F, 32'h4);
        tick();
        lat = 3;
        rst = 1'b0;
        #1;
        chk("postrst_req_valid", imem_req_valid, 1);
        chk("postrst_req_addr", imem_req_addr, 32'h0);

        // Jump with two requests in flight at latency 3
        tick();
        tick();
        chk("jump_pre_addr", imem_req_addr, 32'h8);
        Jump    = 1'b1;
        PCJumpD = 32'h100;
        #1;
        chk("jump_no_issue", imem_req_valid, 0);
        tick();
        Jump = 1'b0;
        #1;
        chk("jump_req_valid", imem_req_valid, 1);
        chk("jump_req_addr", imem_req_addr, 32'h100);
        tick();
        chk("jump_drop0", InstrValidF, 0);
        tick();
        chk("jump_drop1", InstrValidF, 0);
        tick();
        chk("jump_wait", InstrValidF, 0);
        tick();
        chk("jump_valid", InstrValidF, 1);
        chk("jump_pc", PCF, 32'h100);
        chk("jump_instr", InstrF, 32'hC0DE_0100);
        tick();
        chk("jump_pc_next", PCF, 32'h104);

        // Jump wins over branch
        Jump      = 1'b1;
        PCSrcD    = 1'b1;
        PCJumpD   = 32'h200;
        PCBranchD = 32'h300;
        #1;
        chk("both_no_issue", imem_req_valid, 0);
        tick();
        Jump   = 1'b0;
        PCSrcD = 1'b0;
        #1;
        chk("both_req_addr", imem_req_addr, 32'h200);
        chk("both_req_valid", imem_req_valid, 1);
        for (int i = 0; i < 20 && !InstrValidF; i++) tick();
        chk("both_wait_valid", InstrValidF, 1);
        chk("both_pc", PCF, 32'h200);
        chk("both_instr", InstrF, 32'hC0DE_0200);

        // Branch alone
        PCSrcD = 1'b1;
        #1;
        tick();
        PCSrcD = 1'b0;
        #1;
        chk("branch_req_addr", imem_req_addr, 32'h300);
        for (int i = 0; i < 20 && !InstrValidF; i++) tick();
        chk("branch_wait_valid", InstrValidF, 1);
        chk("branch_pc", PCF, 32'h300);

        // Back-pressure: address held, PC advances only on handshake
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        tick();
        lat            = 1;
        imem_req_ready = 1'b0;
        rst            = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_addr", imem_req_addr, 32'h0);
            chk("hold_valid", imem_req_valid, 1);
        end
        imem_req_ready = 1'b1;
        tick();
        chk("hold_advance", imem_req_addr, 32'h4);
        tick();
        chk("hold_pc0", PCF, 32'h0);
        chk("hold_instr0", InstrF, 32'hC0DE_0000);
        chk("hold_addr_next", imem_req_addr, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised, decoupled instruction-fetch stage for the pipelined MIPS core.
- Owns the fetch PC and issues sequential requests to a handshaked instruction memory that may have latency.
- Buffers returned instructions, each with its PC, in a small queue ahead of decode.
- Jump or branch redirects flush the queue and discard responses still in flight.

Parameters:
- DATA_W, 32: instruction width. PC step is DATA_W/8.
- ADDR_W, 32: PC and address width.
- DEPTH, 4: queue entries. Power of two, 2 or more. Also caps requests in flight.
- RESET_PC, 32'h0000_0000: fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- StallF  in  1  decode cannot accept; hold the queue head.
- Jump  in  1  redirect to PCJumpD. Has priority over PCSrcD.
- PCSrcD  in  1  redirect to PCBranchD.
- PCJumpD  in  ADDR_W  jump target.
- PCBranchD  in  ADDR_W  branch target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  ADDR_W  request address.
- imem_rsp_valid  in  1  response valid. Responses return in order, one per accepted request.
- imem_rsp_data  in  DATA_W  response instruction.
- InstrValidF  out  1  queue head is valid.
- InstrF  out  DATA_W  head instruction. Reads 0 when the queue is empty.
- PCF  out  ADDR_W  PC of the head instruction.
- PCPlus4F  out  ADDR_W  PCF + DATA_W/8.

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, queue empty.
  - Outputs during reset: imem_req_valid=0, InstrValidF=0, InstrF=0, PCF=0, PCPlus4F=DATA_W/8.
- Counter widths are $clog2(DEPTH+1). PC arithmetic wraps modulo 2^ADDR_W.
- Redirect: redir = Jump | PCSrcD. Target = Jump ? PCJumpD : PCBranchD.
- Issue rule: imem_req_valid = !redir && (count + outstanding - drop_cnt) < DEPTH.
  - imem_req_addr = fetch_pc.
  - On the handshake: fetch_pc += DATA_W/8 and outstanding increments.
  - The address must be held stable while valid is high and ready is low.
- Response with drop_cnt > 0: discard the data, decrement drop_cnt, decrement outstanding.
- Response with drop_cnt == 0: push {rsp_pc, imem_rsp_data}, rsp_pc += DATA_W/8, decrement outstanding.
- Output: InstrValidF = !empty. InstrF, PCF and PCPlus4F come from the head. Pop when InstrValidF && !StallF && !redir.
- Latency: a response is visible on InstrF the next cycle. No combinational bypass from the memory to InstrF.
- Redirect cycle (highest priority):
  - Queue cleared, head not delivered.
  - fetch_pc <= target, rsp_pc <= target.
  - drop_cnt <= outstanding after this cycle's issue and response accounting. All surviving in-flight responses become stale.
  - A response arriving in the same cycle is discarded.
  - No request is issued.
  - First request to the target goes out in the cycle after the redirect.
- Simultaneous push and pop keeps count unchanged. A push into a full queue is impossible by the credit rule; flag it with an assertion.
- Redirect while a request is held unaccepted: the request is withdrawn, which the handshake permits.
- StallF has no effect on issue except through the credit limit.
- Reset mid-operation clears all state. The memory model shares rst and drops its pending responses.

Decomposition:
- fetch_pkg holds:
  - DEF_DATA_W and DEF_ADDR_W;
  - INSTR_NOP = 32'h0;
  - a typedef for the queue entry struct {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO parametrised by DEPTH and entry width.
  - Ports: push, pop, flush (flush has priority), full, empty, count, head.
  - Async active-high reset.
  - Count width $clog2(DEPTH+1).

Test Plan:
- Zero-latency memory (ready=1, response next cycle), no stalls -> InstrF carries mem[0], mem[4], mem[8]… on consecutive cycles; PCF=0,4,8; PCPlus4F=PCF+4.
- StallF held 10 cycles, DEPTH=4 -> count saturates at 4, outstanding caps so count+outstanding-drop_cnt ≤ 4, no lost or duplicated PCs after release.
- 3-cycle latency, Jump=1 with PCJumpD=0x100 while 2 requests are outstanding -> those 2 responses are dropped; next valid InstrF has PCF=0x100.
- Jump=1 and PCSrcD=1 together (PCJumpD=0x200, PCBranchD=0x300) -> redirect to 0x200.
- imem_req_ready held low for 5 cycles -> imem_req_addr is stable throughout and fetch_pc advances only on the handshake.
- rst asserted mid-stream -> outputs return to reset values within the same cycle; first request after release uses RESET_PC.
